// File: rtl/key_event_ctrl.sv
// N-channel key front end: synchronise, debounce and classify each key into
// press / release / long-press / auto-repeat strobes. Channels are independent.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | key released (debounced), waiting for an accepted press
// PRESSED | key held, hold_cnt timing towards the long-press strobe
// HELD    | long press reported, rep_cnt timing auto-repeat strobes
module key_event_ctrl #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 120000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2400000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key,
    input  logic [N_KEYS-1:0] i_repeat_en,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_TC  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TC = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

    // Raw value of a released key; synchroniser flops reset to it so that
    // leaving reset never looks like an edge.
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic          sync_a;
        logic          sync_b;
        logic          s_q;
        logic [DW-1:0] deb_cnt;
        logic          level;
        logic          accept;
        logic          press_acc;
        logic          rel_acc;

        state_t        state;
        state_t        state_nxt;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_nxt;
        logic [RW-1:0] rep_cnt;
        logic [RW-1:0] rep_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          rel_q;
        logic          rel_nxt;
        logic          long_q;
        logic          long_nxt;
        logic          rpt_q;
        logic          rpt_nxt;

        // s_q is the polarity-normalised sample (1 = pressed) after the
        // two-flop synchroniser.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync_a  <= RAW_IDLE;
                sync_b  <= RAW_IDLE;
                s_q     <= 1'b0;
                deb_cnt <= '0;
                level   <= 1'b0;
            end else begin
                sync_a <= i_key[g];
                sync_b <= sync_a;
                s_q    <= sync_b ^ RAW_IDLE;
                if (s_q != level) begin
                    if (deb_cnt == DEB_TC) begin
                        level   <= s_q;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end else begin
                    deb_cnt <= '0;
                end
            end
        end

        assign accept    = (s_q != level) && (deb_cnt == DEB_TC);
        assign press_acc = accept && s_q;
        assign rel_acc   = accept && !s_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                rpt_q    <= 1'b0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                rep_cnt  <= rep_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                long_q   <= long_nxt;
                rpt_q    <= rpt_nxt;
            end
        end

        // Release is tested first so it suppresses a long/repeat strobe
        // falling on the same cycle.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            rep_nxt   = rep_cnt;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            long_nxt  = 1'b0;
            rpt_nxt   = 1'b0;
            unique case (state)
                IDLE: begin
                    if (press_acc) begin
                        press_nxt = 1'b1;
                        hold_nxt  = '0;
                        state_nxt = PRESSED;
                    end
                end
                PRESSED: begin
                    if (rel_acc) begin
                        rel_nxt   = 1'b1;
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                    end else if (hold_cnt == HOLD_TC) begin
                        long_nxt  = 1'b1;
                        hold_nxt  = '0;
                        rep_nxt   = '0;
                        state_nxt = HELD;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (rel_acc) begin
                        rel_nxt   = 1'b1;
                        rep_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (!i_repeat_en[g]) begin
                        rep_nxt = '0;
                    end else if (rep_cnt == REP_TC) begin
                        rpt_nxt = 1'b1;
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end
            endcase
        end

        assign o_level[g]   = level;
        assign o_press[g]   = press_q;
        assign o_release[g] = rel_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = rpt_q;
    end

endmodule
